decode_stage_sb: RTL and testbench

- Parametrised next-generation decode stage with an integrated N_REG-entry register file and a per-register busy scoreboard.
- Replaces the single global "reserved" stall with per-register RAW/WAW hazard detection, and forwards same-cycle writebacks into operand reads.
- Adds an optional hardwired-zero R0.
- Sits between fetch (v_i/stall_o) and execute (v_o/stall_i). Execute returns results through the wb_* port.

---
 rtl/decode_stage_sb_pkg.sv | 51 +++++
 rtl/sb_regfile.sv | 67 ++++++
 rtl/decode_stage_sb.sv | 122 ++++++++++++
 tb/tb_decode_stage_sb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_sb_pkg.sv
// Shared decode helpers for the scoreboarded decode stage: field offsets,
// opcode decode and immediate extension, all independent of module parameters.
package decode_stage_sb_pkg;

  localparam int DEF_WORD  = 32;
  localparam int DEF_N_REG = 16;
  localparam int DEF_W_IMM = 16;
  localparam int DEF_W_OPR = 32;
  localparam int MAX_W     = 64;

  typedef struct packed {
    logic writes;
    logic sext;
  } dec_t;

  // Instruction layout, LSB first: imm, rs, rd, immf, opc.
  function automatic int rs_lsb(input int w_imm);
    return w_imm;
  endfunction

  function automatic int rd_lsb(input int w_imm, input int w_rd);
    return w_imm + w_rd;
  endfunction

  function automatic int immf_bit(input int w_imm, input int w_rd);
    return w_imm + 2 * w_rd;
  endfunction

  function automatic int opc_lsb(input int w_imm, input int w_rd);
    return w_imm + 2 * w_rd + 1;
  endfunction

  function automatic dec_t decode_opc(input logic opc_msb, input logic opc_lsb_bit);
    dec_t d;
    d.writes = ~opc_msb;
    d.sext   = opc_lsb_bit;
    return d;
  endfunction

  // Extends the low w_imm bits of imm to MAX_W bits; callers truncate.
  function automatic logic [MAX_W-1:0] imm_ext(input logic [MAX_W-1:0] imm,
                                               input int               w_imm,
                                               input logic             sext);
    logic [MAX_W-1:0] mask;
    logic             sign;
    mask = ~({MAX_W{1'b1}} << w_imm);
    sign = |(imm & mask & ~(mask >> 1));
    return (imm & mask) | ((sext && sign) ? ~mask : '0);
  endfunction

endpackage

// File: rtl/sb_regfile.sv
// Register file with per-register busy scoreboard, two forwarded read ports,
// a writeback (write + clear) port and an issue (set busy) port.
module sb_regfile #(
  parameter int N_REG   = 16,
  parameter int W_OPR   = 32,
  parameter int R0_ZERO = 1,
  localparam int W_RD   = $clog2(N_REG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W_RD-1:0]  ra_i,
  input  logic [W_RD-1:0]  rb_i,
  output logic [W_OPR-1:0] ra_data_o,
  output logic [W_OPR-1:0] rb_data_o,
  input  logic             wb_i,
  input  logic [W_RD-1:0]  wb_r_i,
  input  logic [W_OPR-1:0] result_i,
  input  logic             set_i,
  input  logic [W_RD-1:0]  set_r_i,
  output logic [N_REG-1:0] eff_busy_o
);

  logic [W_OPR-1:0] rf_q [N_REG];
  logic [N_REG-1:0] busy_q;
  logic [N_REG-1:0] busy_d;
  logic [N_REG-1:0] wb_onehot;

  function automatic logic is_r0(input logic [W_RD-1:0] r);
    return (R0_ZERO != 0) && (r == '0);
  endfunction

  // A same-cycle writeback bypasses the array so issue never waits an extra cycle.
  assign ra_data_o = is_r0(ra_i)                 ? '0       :
                     (wb_i && (wb_r_i == ra_i))  ? result_i : rf_q[ra_i];
  assign rb_data_o = is_r0(rb_i)                 ? '0       :
                     (wb_i && (wb_r_i == rb_i))  ? result_i : rf_q[rb_i];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wb_onehot = '0;
    if (wb_i) wb_onehot[wb_r_i] = 1'b1;
  end

  assign eff_busy_o = busy_q & ~wb_onehot;

  // Clear from writeback first, then set from issue, so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_i)  busy_d[wb_r_i]  = 1'b0;
    if (set_i) busy_d[set_r_i] = 1'b1;
    if (R0_ZERO != 0) busy_d[0] = 1'b0;
  end

  // NOTE: the register array is reset explicitly because reads after reset
  // must return 0; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_q   <= '{default: '0};
      busy_q <= '0;
    end else begin
      if (wb_i && !is_r0(wb_r_i)) rf_q[wb_r_i] <= result_i;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/decode_stage_sb.sv
// Decode stage with per-register RAW/WAW hazard detection, writeback
// forwarding and a one-deep registered output bundle towards execute.
module decode_stage_sb
  import decode_stage_sb_pkg::*;
#(
  parameter int WORD    = DEF_WORD,
  parameter int N_REG   = DEF_N_REG,
  parameter int W_IMM   = DEF_W_IMM,
  parameter int W_OPR   = DEF_W_OPR,
  parameter int R0_ZERO = 1,
  localparam int W_RD   = $clog2(N_REG),
  localparam int W_OPC  = WORD - 1 - 2 * W_RD - W_IMM
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  output logic             stall_o,
  input  logic [WORD-1:0]  inst_i,
  output logic             v_o,
  input  logic             stall_i,
  output logic [W_OPC-1:0] opecode_o,
  output logic [W_OPR-1:0] opr0_o,
  output logic [W_OPR-1:0] opr1_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic             wb_en_o,
  input  logic             wb_i,
  input  logic [W_RD-1:0]  wb_r_i,
  input  logic [W_OPR-1:0] result_i
);

  localparam int RS_LSB   = rs_lsb(W_IMM);
  localparam int RD_LSB   = rd_lsb(W_IMM, W_RD);
  localparam int IMMF_BIT = immf_bit(W_IMM, W_RD);
  localparam int OPC_LSB  = opc_lsb(W_IMM, W_RD);

  logic [W_OPC-1:0] opc;
  logic             immf;
  logic [W_RD-1:0]  rd;
  logic [W_RD-1:0]  rs;
  logic [W_IMM-1:0] imm;
  dec_t             dec;
  logic [W_OPR-1:0] rd_val;
  logic [W_OPR-1:0] rs_val;
  logic [W_OPR-1:0] opr1_d;
  logic [N_REG-1:0] eff_busy;
  logic             hazard;
  logic             hold;
  logic             accept;
  logic             set_en;

  logic             v_q;
  logic [W_OPC-1:0] opc_q;
  logic [W_OPR-1:0] opr0_q;
  logic [W_OPR-1:0] opr1_q;
  logic [W_RD-1:0]  wb_r_q;
  logic             wb_en_q;

  assign opc  = inst_i[OPC_LSB +: W_OPC];
  assign immf = inst_i[IMMF_BIT];
  assign rd   = inst_i[RD_LSB +: W_RD];
  assign rs   = inst_i[RS_LSB +: W_RD];
  assign imm  = inst_i[W_IMM-1:0];
  assign dec  = decode_opc(opc[W_OPC-1], opc[0]);

  assign opr1_d = immf ? W_OPR'(imm_ext(MAX_W'(imm), W_IMM, dec.sext)) : rs_val;

  sb_regfile #(
    .N_REG   (N_REG),
    .W_OPR   (W_OPR),
    .R0_ZERO (R0_ZERO)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .ra_i       (rd),
    .rb_i       (rs),
    .ra_data_o  (rd_val),
    .rb_data_o  (rs_val),
    .wb_i       (wb_i),
    .wb_r_i     (wb_r_i),
    .result_i   (result_i),
    .set_i      (set_en),
    .set_r_i    (rd),
    .eff_busy_o (eff_busy)
  );

  // rd is always a source, so a busy rd covers both RAW on rd and WAW.
  assign hazard  = v_i && (eff_busy[rd] || (!immf && eff_busy[rs]));
  assign hold    = v_q && stall_i;
  assign accept  = v_i && !hazard && !hold;
  assign stall_o = v_i && (hazard || hold);
  assign set_en  = accept && dec.writes && !((R0_ZERO != 0) && (rd == '0));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q     <= 1'b0;
      opc_q   <= '0;
      opr0_q  <= '0;
      opr1_q  <= '0;
      wb_r_q  <= '0;
      wb_en_q <= 1'b0;
    end else if (accept) begin
      v_q     <= 1'b1;
      opc_q   <= opc;
      opr0_q  <= rd_val;
      opr1_q  <= opr1_d;
      wb_r_q  <= rd;
      wb_en_q <= dec.writes;
    end else if (!hold) begin
      v_q <= 1'b0;
    end
  end

  assign v_o       = v_q;
  assign opecode_o = opc_q;
  assign opr0_o    = opr0_q;
  assign opr1_o    = opr1_q;
  assign wb_r_o    = wb_r_q;
  assign wb_en_o   = wb_en_q;

endmodule

// File: tb/tb_decode_stage_sb.sv
// Directed and randomized bench for decode_stage_sb against a register-level
// reference model of the decode/scoreboard rules.
module tb_decode_stage_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        v_i;
  logic        stall_o;
  logic [31:0] inst_i;
  logic        v_o;
  logic        stall_i;
  logic [6:0]  opecode_o;
  logic [31:0] opr0_o;
  logic [31:0] opr1_o;
  logic [3:0]  wb_r_o;
  logic        wb_en_o;
  logic        wb_i;
  logic [3:0]  wb_r_i;
  logic [31:0] result_i;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] reg_m [16];
  bit          busy_m [16];
  bit          exp_v;
  logic [6:0]  exp_opc;
  logic [31:0] exp_opr0;
  logic [31:0] exp_opr1;
  logic [3:0]  exp_wbr;
  bit          exp_wben;

  always #5 clk = ~clk;

  decode_stage_sb #(
    .WORD    (32),
    .N_REG   (16),
    .W_IMM   (16),
    .W_OPR   (32),
    .R0_ZERO (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .v_i       (v_i),
    .stall_o   (stall_o),
    .inst_i    (inst_i),
    .v_o       (v_o),
    .stall_i   (stall_i),
    .opecode_o (opecode_o),
    .opr0_o    (opr0_o),
    .opr1_o    (opr1_o),
    .wb_r_o    (wb_r_o),
    .wb_en_o   (wb_en_o),
    .wb_i      (wb_i),
    .wb_r_i    (wb_r_i),
    .result_i  (result_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic immf,
                                     input logic [3:0] rd, input logic [3:0] rs,
                                     input logic [15:0] imm);
    return {opc, immf, rd, rs, imm};
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] x, input logic wb,
                                         input logic [3:0] wr, input logic [31:0] res);
    if (x == 4'd0) return 32'h0;
    if (wb && wr == x) return res;
    return reg_m[x];
  endfunction

  function automatic bit m_busy(input logic [3:0] x, input logic wb, input logic [3:0] wr);
    return busy_m[x] && !(wb && wr == x);
  endfunction

  function automatic bit m_stall(input logic v, input logic [31:0] inst, input logic st,
                                 input logic wb, input logic [3:0] wr);
    bit haz;
    haz = m_busy(inst[23:20], wb, wr) || (!inst[24] && m_busy(inst[19:16], wb, wr));
    return v && (haz || (exp_v && st));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      reg_m[i]  = 32'h0;
      busy_m[i] = 1'b0;
    end
    exp_v = 0; exp_opc = '0; exp_opr0 = '0; exp_opr1 = '0; exp_wbr = '0; exp_wben = 0;
  endfunction

  // One clock: drive at start, check mid-cycle, update the model at the edge.
  task automatic step(input string tag, input logic v, input logic [31:0] inst,
                      input logic st, input logic wb, input logic [3:0] wr,
                      input logic [31:0] res);
    bit          stl;
    bit          acc;
    logic [31:0] o0, o1;
    v_i = v; inst_i = inst; stall_i = st; wb_i = wb; wb_r_i = wr; result_i = res;
    @(negedge clk);
    stl = m_stall(v, inst, st, wb, wr);
    chk({tag, ":stall_o"}, 32'(stall_o), 32'(stl));
    chk({tag, ":v_o"}, 32'(v_o), 32'(exp_v));
    if (exp_v) begin
      chk({tag, ":opecode"}, 32'(opecode_o), 32'(exp_opc));
      chk({tag, ":opr0"}, opr0_o, exp_opr0);
      chk({tag, ":opr1"}, opr1_o, exp_opr1);
      chk({tag, ":wb_r"}, 32'(wb_r_o), 32'(exp_wbr));
      chk({tag, ":wb_en"}, 32'(wb_en_o), 32'(exp_wben));
    end
    acc = v && !stl;
    o0 = m_read(inst[23:20], wb, wr, res);
    if (inst[24]) o1 = inst[25] ? 32'($signed(inst[15:0])) : {16'h0, inst[15:0]};
    else          o1 = m_read(inst[19:16], wb, wr, res);
    @(posedge clk);
    if (acc) begin
      exp_v = 1; exp_opc = inst[31:25]; exp_opr0 = o0; exp_opr1 = o1;
      exp_wbr = inst[23:20]; exp_wben = !inst[31];
    end else if (!(exp_v && st)) begin
      exp_v = 0;
    end
    if (wb && wr != 4'd0) begin
      reg_m[wr]  = res;
      busy_m[wr] = 1'b0;
    end
    if (acc && !inst[31] && inst[23:20] != 4'd0) busy_m[inst[23:20]] = 1'b1;
    #1;
  endtask

  task automatic do_reset(input string tag);
    v_i = 0; stall_i = 0; wb_i = 0; wb_r_i = '0; result_i = '0; inst_i = '0;
    reset = 1'b1;
    #2;
    model_reset();
    chk({tag, ":rst_v_o"}, 32'(v_o), 32'h0);
    chk({tag, ":rst_stall_o"}, 32'(stall_o), 32'h0);
    chk({tag, ":rst_opc"}, 32'(opecode_o), 32'h0);
    chk({tag, ":rst_opr0"}, opr0_o, 32'h0);
    chk({tag, ":rst_opr1"}, opr1_o, 32'h0);
    chk({tag, ":rst_wb_r"}, 32'(wb_r_o), 32'h0);
    chk({tag, ":rst_wb_en"}, 32'(wb_en_o), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] cur;
    logic        cur_v;
    bit          have;
    logic        st, wb;
    logic [3:0]  wr;
    logic [31:0] res;
    int          busy_list [$];

    model_reset();
    reset = 1'b1;
    v_i = 0; stall_i = 0; wb_i = 0; wb_r_i = '0; result_i = '0; inst_i = '0;
    repeat (2) @(posedge clk);
    #1;

    // 1: immediate write with sign extension
    do_reset("t1");
    step("t1_idle", 0, 32'h0, 0, 0, 4'd0, 32'h0);
    step("t1_issue", 1, mk(7'h01, 1, 4'd3, 4'd0, 16'hFFFF), 0, 0, 4'd0, 32'h0);
    chk("t1_v_o", 32'(v_o), 32'h1);
    chk("t1_opr1", opr1_o, 32'hFFFF_FFFF);
    chk("t1_wb_r", 32'(wb_r_o), 32'h3);
    chk("t1_wb_en", 32'(wb_en_o), 32'h1);

    // 2: RAW on rs=3 stalls until its writeback, which is forwarded
    step("t2_raw_a", 1, mk(7'h02, 0, 4'd4, 4'd3, 16'h0), 0, 0, 4'd0, 32'h0);
    chk("t2_stall_held", 32'(stall_o), 32'h1);
    step("t2_raw_b", 1, mk(7'h02, 0, 4'd4, 4'd3, 16'h0), 0, 0, 4'd0, 32'h0);
    step("t2_wb", 1, mk(7'h02, 0, 4'd4, 4'd3, 16'h0), 0, 1, 4'd3, 32'h1234);
    chk("t2_fwd_opr1", opr1_o, 32'h1234);
    chk("t2_fwd_v_o", 32'(v_o), 32'h1);
    step("t2_drain", 0, 32'h0, 0, 0, 4'd0, 32'h0);

    // 3: WAW on r5, set wins over same-cycle clear
    do_reset("t3");
    step("t3_w1", 1, mk(7'h00, 1, 4'd5, 4'd0, 16'h0011), 0, 0, 4'd0, 32'h0);
    step("t3_w2_stall", 1, mk(7'h00, 1, 4'd5, 4'd0, 16'h0022), 0, 0, 4'd0, 32'h0);
    step("t3_w2_wb", 1, mk(7'h00, 1, 4'd5, 4'd0, 16'h0022), 0, 1, 4'd5, 32'h55);
    chk("t3_w2_opr1", opr1_o, 32'h22);
    step("t3_read5", 1, mk(7'h40, 1, 4'd5, 4'd0, 16'h0), 0, 0, 4'd0, 32'h0);
    chk("t3_set_wins", 32'(stall_o), 32'h1);

    // 4: execute back-pressure holds the bundle
    do_reset("t4");
    step("t4_w1", 1, mk(7'h00, 1, 4'd1, 4'd0, 16'h0101), 0, 0, 4'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step("t4_hold", 1, mk(7'h00, 1, 4'd2, 4'd0, 16'h0202), 1, 0, 4'd0, 32'h0);
      chk("t4_hold_opr1", opr1_o, 32'h0101);
      chk("t4_hold_v_o", 32'(v_o), 32'h1);
    end
    step("t4_release", 1, mk(7'h00, 1, 4'd2, 4'd0, 16'h0202), 0, 0, 4'd0, 32'h0);
    chk("t4_next_opr1", opr1_o, 32'h0202);
    chk("t4_next_wb_r", 32'(wb_r_o), 32'h2);

    // 5: hardwired-zero r0
    do_reset("t5");
    step("t5_w0", 1, mk(7'h00, 1, 4'd0, 4'd0, 16'hBEEF), 0, 0, 4'd0, 32'h0);
    step("t5_r0_wb", 1, mk(7'h40, 0, 4'd0, 4'd0, 16'h0), 0, 1, 4'd0, 32'hDEAD);
    chk("t5_r0_opr0", opr0_o, 32'h0);
    chk("t5_r0_opr1", opr1_o, 32'h0);
    step("t5_r0_again", 1, mk(7'h40, 0, 4'd0, 4'd0, 16'h0), 0, 0, 4'd0, 32'h0);
    chk("t5_r0_late_opr0", opr0_o, 32'h0);

    // 6: asynchronous reset in the middle of a stall
    do_reset("t6");
    step("t6_w7", 1, mk(7'h00, 1, 4'd7, 4'd0, 16'h7777), 0, 0, 4'd0, 32'h0);
    step("t6_stall", 1, mk(7'h40, 0, 4'd7, 4'd7, 16'h0), 0, 0, 4'd0, 32'h0);
    chk("t6_stalled", 32'(stall_o), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t6_async_v_o", 32'(v_o), 32'h0);
    chk("t6_async_stall_o", 32'(stall_o), 32'h0);
    chk("t6_async_opr1", opr1_o, 32'h0);
    @(negedge clk);
    v_i = 0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    step("t6_read7", 1, mk(7'h40, 0, 4'd7, 4'd7, 16'h0), 0, 0, 4'd0, 32'h0);
    chk("t6_r7_opr0", opr0_o, 32'h0);
    chk("t6_r7_opr1", opr1_o, 32'h0);

    // Randomized traffic: fetch holds stalled instructions, execute returns
    // results for outstanding registers after random delays.
    do_reset("rnd");
    have = 0;
    cur = '0;
    cur_v = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!have) begin
        cur_v = ($urandom_range(0, 9) < 7);
        cur = mk(7'($urandom), 1'($urandom), 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 7)), 16'($urandom));
      end
      st = ($urandom_range(0, 3) == 0);
      busy_list.delete();
      for (int r = 0; r < 16; r++) if (busy_m[r]) busy_list.push_back(r);
      wb = 0;
      wr = '0;
      if (busy_list.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb = 1;
        wr = 4'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      end else if ($urandom_range(0, 9) == 0) begin
        wb = 1;
        wr = 4'($urandom_range(0, 15));
      end
      res = $urandom;
      have = m_stall(cur_v, cur, st, wb, wr);
      step("rnd", cur_v, cur, st, wb, wr, res);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
